seven_segment_reader: RTL and testbench

- Recovers symbols from a 7-segment bus driven by the team's hex display driver: active-low segments a..g, blank and dash codes.
- Filters glitches, decodes each stable pattern into a hex digit or a symbol class, and emits one event per change over a valid/ready handshake.
- Used as a loopback checker on the display path and as the front end of the self-test readback unit.

---
 rtl/seven_segment_reader_if.sv | 11 +
 rtl/seven_segment_reader.sv | 138 +++++++++++++
 tb/tb_seven_segment_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_reader_if.sv
// Decoded-event handshake between the segment reader and its consumer.
// The reader drives valid/digit/kind; the consumer drives ready.
interface seven_segment_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic [1:0] out_kind;

  modport master (output out_valid, output out_digit, output out_kind, input out_ready);
  modport slave  (input out_valid, input out_digit, input out_kind, output out_ready);
endinterface

// File: rtl/seven_segment_reader.sv
// Glitch-filtering decoder for an active-low 7-segment bus; emits one event per
// accepted pattern change into a one-entry holding register with overrun flag.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    seg_n,
  seven_segment_reader_if.master        out_if,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUALIFY = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam logic [1:0] KIND_DIGIT   = 2'd0;
  localparam logic [1:0] KIND_BLANK   = 2'd1;
  localparam logic [1:0] KIND_DASH    = 2'd2;
  localparam logic [1:0] KIND_INVALID = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               DIRECT_EMIT = (STABLE_CYCLES == 1);

  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b0000001: r = {KIND_DIGIT, 4'h0};
      7'b1001111: r = {KIND_DIGIT, 4'h1};
      7'b0010010: r = {KIND_DIGIT, 4'h2};
      7'b0000110: r = {KIND_DIGIT, 4'h3};
      7'b1001100: r = {KIND_DIGIT, 4'h4};
      7'b0100100: r = {KIND_DIGIT, 4'h5};
      7'b0100000: r = {KIND_DIGIT, 4'h6};
      7'b0001111: r = {KIND_DIGIT, 4'h7};
      7'b0000000: r = {KIND_DIGIT, 4'h8};
      7'b0000100: r = {KIND_DIGIT, 4'h9};
      7'b0001000: r = {KIND_DIGIT, 4'hA};
      7'b1100000: r = {KIND_DIGIT, 4'hB};
      7'b0110001: r = {KIND_DIGIT, 4'hC};
      7'b1000010: r = {KIND_DIGIT, 4'hD};
      7'b0110000: r = {KIND_DIGIT, 4'hE};
      7'b0111000: r = {KIND_DIGIT, 4'hF};
      SEG_BLANK:  r = {KIND_BLANK, 4'h0};
      SEG_DASH:   r = {KIND_DASH, 4'h0};
      default:    r = {KIND_INVALID, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]       seg_q;
  logic [6:0]       last_accepted;
  logic [6:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       state;
  logic             emit;
  logic [5:0]       event_code;

  assign cnt_inc    = cnt + 1'b1;
  assign emit       = (state == S_EMIT);
  assign event_code = decode(cand);

  // Stage 1: input register and qualification FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q         <= SEG_BLANK;
      last_accepted <= SEG_BLANK;
      cand          <= SEG_BLANK;
      cnt           <= '0;
      state         <= S_IDLE;
    end else begin
      seg_q <= seg_n;
      case (state)
        S_IDLE: begin
          if (seg_q != last_accepted) begin
            cand  <= seg_q;
            cnt   <= '0;
            state <= DIRECT_EMIT ? S_EMIT : S_QUALIFY;
          end
        end
        S_QUALIFY: begin
          if (seg_q == last_accepted) begin
            state <= S_IDLE;
          end else if (seg_q != cand) begin
            cand <= seg_q;
            cnt  <= '0;
          end else if (cnt_inc == LAST_CNT) begin
            state <= S_EMIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_EMIT: begin
          last_accepted <= cand;
          // A pattern already differing from the one just accepted starts a new qualification.
          if (seg_q != cand) begin
            cand  <= seg_q;
            cnt   <= '0;
            state <= DIRECT_EMIT ? S_EMIT : S_QUALIFY;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 2: one-entry output holding register and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_if.out_valid <= 1'b0;
      out_if.out_digit <= 4'h0;
      out_if.out_kind  <= KIND_BLANK;
      overrun          <= 1'b0;
    end else begin
      if (emit && (!out_if.out_valid || out_if.out_ready)) begin
        out_if.out_valid <= 1'b1;
        out_if.out_kind  <= event_code[5:4];
        out_if.out_digit <= event_code[3:0];
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end

      if (emit && out_if.out_valid && !out_if.out_ready)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: decode table vectors, hand-written corner
// sequences and randomized traffic checked against a run-length reference model.
module tb_seven_segment_reader;

  localparam int STABLE = 4;
  localparam int NT     = 20;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] kind;
    logic [3:0] digit;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_n;
  logic       overrun;
  logic       clr_overrun;

  seven_segment_reader_if bus ();

  seven_segment_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .out_if      (bus),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [NT];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: run length of the sampled bus plus a 2-edge event delay
  logic [6:0] m_prev, m_last;
  int         m_run;
  logic       p1_v, p2_v;
  logic [5:0] p1_e, p2_e;
  logic       m_valid, m_ovr;
  logic [1:0] m_kind;
  logic [3:0] m_digit;

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    logic [5:0] r;
    r = {2'd3, 4'd0};
    for (int i = 0; i < NT; i++)
      if (tbl[i].seg == s) r = {tbl[i].kind, tbl[i].digit};
    return r;
  endfunction

  task automatic model_edge();
    logic       fire_v, set_ovr;
    logic [5:0] fire_e;
    if (!rst_n) begin
      m_prev = 7'h7F; m_last = 7'h7F; m_run = 0;
      p1_v = 1'b0; p2_v = 1'b0; p1_e = '0; p2_e = '0;
      m_valid = 1'b0; m_kind = 2'd1; m_digit = 4'd0; m_ovr = 1'b0;
    end else begin
      fire_v = p2_v; fire_e = p2_e;
      p2_v = p1_v; p2_e = p1_e;
      if (seg_n == m_prev) m_run++;
      else begin m_run = 1; m_prev = seg_n; end
      p1_v = (m_run == STABLE) && (seg_n != m_last);
      p1_e = ref_decode(seg_n);
      if (p1_v) m_last = seg_n;
      set_ovr = fire_v && m_valid && !bus.out_ready;
      if (fire_v && (!m_valid || bus.out_ready)) begin
        m_valid = 1'b1; m_kind = fire_e[5:4]; m_digit = fire_e[3:0];
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", bus.out_valid, m_valid);
    chk("model_overrun", overrun, m_ovr);
    if (m_valid) begin
      chk("model_kind", bus.out_kind, m_kind);
      chk("model_digit", bus.out_digit, m_digit);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.out_valid && n < limit);
    chk("wait_valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  int n, cnt_ev;

  initial begin
    tbl[0]  = '{7'b0000001, 2'd0, 4'h0};
    tbl[1]  = '{7'b1001111, 2'd0, 4'h1};
    tbl[2]  = '{7'b0010010, 2'd0, 4'h2};
    tbl[3]  = '{7'b0000110, 2'd0, 4'h3};
    tbl[4]  = '{7'b1001100, 2'd0, 4'h4};
    tbl[5]  = '{7'b0100100, 2'd0, 4'h5};
    tbl[6]  = '{7'b0100000, 2'd0, 4'h6};
    tbl[7]  = '{7'b0001111, 2'd0, 4'h7};
    tbl[8]  = '{7'b0000000, 2'd0, 4'h8};
    tbl[9]  = '{7'b0000100, 2'd0, 4'h9};
    tbl[10] = '{7'b0001000, 2'd0, 4'hA};
    tbl[11] = '{7'b1100000, 2'd0, 4'hB};
    tbl[12] = '{7'b0110001, 2'd0, 4'hC};
    tbl[13] = '{7'b1000010, 2'd0, 4'hD};
    tbl[14] = '{7'b0110000, 2'd0, 4'hE};
    tbl[15] = '{7'b0111000, 2'd0, 4'hF};
    tbl[16] = '{7'b1111110, 2'd2, 4'h0};
    tbl[17] = '{7'b0101010, 2'd3, 4'h0};
    tbl[18] = '{7'b1111111, 2'd1, 4'h0};
    tbl[19] = '{7'b1010101, 2'd3, 4'h0};

    rst_n = 1'b0; seg_n = 7'h7F; bus.out_ready = 1'b1; clr_overrun = 1'b0;
    steps(3);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_kind", bus.out_kind, 2'd1);
    chk("reset_digit", bus.out_digit, 4'd0);
    chk("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    steps(50);
    chk("idle_blank_valid", bus.out_valid, 1'b0);
    chk("idle_blank_kind", bus.out_kind, 2'd1);

    // Latency and single event for digit 2
    seg_n = 7'b0010010;
    wait_valid(20, n);
    chk("latency_2", n, STABLE + 2);
    chk("digit_2", bus.out_digit, 4'h2);
    chk("kind_2", bus.out_kind, 2'd0);
    cnt_ev = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.out_valid) cnt_ev++; end
    chk("single_event_2", cnt_ev, 0);

    // Short glitch is filtered, then C qualifies
    do_reset();
    seg_n = 7'b1001111; steps(2);
    seg_n = 7'h7F;
    cnt_ev = 0;
    for (int i = 0; i < 12; i++) begin step(); if (bus.out_valid) cnt_ev++; end
    chk("glitch_no_event", cnt_ev, 0);
    seg_n = 7'b0110001;
    wait_valid(20, n);
    chk("digit_C", bus.out_digit, 4'hC);

    // Backpressure: held event survives, dash dropped, overrun sticky vs clear
    do_reset();
    bus.out_ready = 1'b0;
    seg_n = 7'b0000000; steps(10);
    seg_n = 7'b1111110; steps(10);
    chk("hold_valid", bus.out_valid, 1'b1);
    chk("hold_digit_8", bus.out_digit, 4'h8);
    chk("hold_kind", bus.out_kind, 2'd0);
    chk("overrun_set", overrun, 1'b1);
    seg_n = 7'b0000001;
    steps(STABLE + 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("set_and_clear", overrun, 1'b1);
    chk("still_digit_8", bus.out_digit, 4'h8);
    step();
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("lone_clear", overrun, 1'b0);
    bus.out_ready = 1'b1; steps(2);

    // Invalid pattern then dash
    do_reset();
    seg_n = 7'b0101010;
    wait_valid(20, n);
    chk("invalid_kind", bus.out_kind, 2'd3);
    chk("invalid_digit", bus.out_digit, 4'd0);
    seg_n = 7'b1111110;
    wait_valid(20, n);
    chk("dash_kind", bus.out_kind, 2'd2);

    // Reset in the middle of qualifying 9
    do_reset();
    seg_n = 7'b0000100; steps(3);
    rst_n = 1'b0; steps(2);
    chk("mid_reset_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    wait_valid(20, n);
    chk("post_reset_latency", n, STABLE + 2);
    chk("post_reset_digit_9", bus.out_digit, 4'h9);

    // Decode table walk
    for (int i = 0; i < NT; i++) begin
      seg_n = tbl[i].seg;
      wait_valid(20, n);
      chk("tbl_latency", n, STABLE + 2);
      chk("tbl_kind", bus.out_kind, tbl[i].kind);
      chk("tbl_digit", bus.out_digit, tbl[i].digit);
      steps(2);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      int idx, hold;
      idx  = $urandom_range(0, NT - 1);
      hold = $urandom_range(1, 8);
      seg_n = tbl[idx].seg;
      for (int j = 0; j < hold; j++) begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        clr_overrun   = ($urandom_range(0, 19) == 0);
        rst_n         = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    rst_n = 1'b1; clr_overrun = 1'b0; bus.out_ready = 1'b1;
    steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
